// File: rtl/pipe_controller.sv
// pipe_controller: ID-stage decode plus EX/MEM/WB control pipeline for a
// 5-stage RV32I(+M) core. Detects load-use and branch-operand hazards, tracks
// multi-cycle divide occupancy in EX, and drives stall / flush / PC-select.
module pipe_controller #(
  parameter int RFIDX_WIDTH = 5,
  parameter int HAS_M       = 0,
  parameter int DIV_CYCLES  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [31:0]            id_instr,
  input  logic                   cmp_zero,
  input  logic                   cmp_lt,
  output logic [4:0]             immctrl,
  output logic                   bunsigned,
  output logic                   id_illegal,
  output logic                   id_stall,
  output logic                   id_flush,
  output logic [1:0]             pcsrc,
  output logic                   ex_busy,
  output logic [3:0]             ex_aluctrl,
  output logic [1:0]             ex_alusrca,
  output logic                   ex_alusrcb,
  output logic                   ex_muldiv,
  output logic [RFIDX_WIDTH-1:0] ex_rd,
  output logic                   mem_memwrite,
  output logic [1:0]             mem_lwhb,
  output logic [1:0]             mem_swhb,
  output logic                   mem_lunsigned,
  output logic [RFIDX_WIDTH-1:0] mem_rd,
  output logic                   wb_regwrite,
  output logic                   wb_memtoreg,
  output logic [RFIDX_WIDTH-1:0] wb_rd
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_SLL   = 4'b1010;
  localparam logic [3:0] ALU_SRL   = 4'b1011;
  localparam logic [3:0] ALU_SRA   = 4'b1100;
  localparam logic [3:0] ALU_LUI   = 4'b1101;
  localparam logic [3:0] ALU_AUIPC = 4'b1110;

  // ALU operand A select: rs1, pc, or pc+4 link value for jal/jalr
  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_LINK = 2'b10;

  // immctrl one-hot {i,s,b,u,j}
  localparam logic [4:0] IMM_I = 5'b10000;
  localparam logic [4:0] IMM_S = 5'b01000;
  localparam logic [4:0] IMM_B = 5'b00100;
  localparam logic [4:0] IMM_U = 5'b00010;
  localparam logic [4:0] IMM_J = 5'b00001;

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  typedef struct packed {
    logic [3:0]             aluctrl;
    logic [1:0]             alusrca;
    logic                   alusrcb;
    logic                   muldiv;
    logic                   memread;
    logic                   memwrite;
    logic [1:0]             lwhb;
    logic [1:0]             swhb;
    logic                   lunsigned;
    logic                   regwrite;
    logic                   memtoreg;
    logic [RFIDX_WIDTH-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic                   memread;
    logic                   memwrite;
    logic [1:0]             lwhb;
    logic [1:0]             swhb;
    logic                   lunsigned;
    logic                   regwrite;
    logic                   memtoreg;
    logic [RFIDX_WIDTH-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                   regwrite;
    logic                   memtoreg;
    logic [RFIDX_WIDTH-1:0] rd;
  } wb_ctrl_t;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  // ALU code for OP / OP-IMM given funct3 and the funct7[5] alternate bit
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  logic [6:0]             opcode;
  logic [2:0]             f3;
  logic [6:0]             f7;
  logic [RFIDX_WIDTH-1:0] rd_f, rs1, rs2;

  assign opcode = id_instr[6:0];
  assign f3     = id_instr[14:12];
  assign f7     = id_instr[31:25];
  assign rd_f   = RFIDX_WIDTH'(id_instr[11:7]);
  assign rs1    = RFIDX_WIDTH'(id_instr[19:15]);
  assign rs2    = RFIDX_WIDTH'(id_instr[24:20]);

  ex_ctrl_t  dec;
  logic      dec_isdiv, legal, is_br, is_jal, is_jalr, rs1_used, rs2_used;
  logic [4:0] imm_sel;

  ex_ctrl_t  ex_q, ex_d;
  mem_ctrl_t mem_q, mem_d;
  wb_ctrl_t  wb_q, wb_d;
  state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic id_ok, busy, ex_match, mem_match, load_use, br_haz, hazard, taken, redirect;

  // Instruction decode: control bundle, legality, operand usage, imm type
  always_comb begin
    dec       = '0;
    dec_isdiv = 1'b0;
    legal     = 1'b0;
    is_br     = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    imm_sel   = '0;
    case (opcode)
      OP_LUI: begin
        legal = 1'b1; imm_sel = IMM_U;
        dec.aluctrl = ALU_LUI; dec.alusrcb = 1'b1; dec.regwrite = 1'b1;
      end
      OP_AUIPC: begin
        legal = 1'b1; imm_sel = IMM_U;
        dec.aluctrl = ALU_AUIPC; dec.alusrca = SRCA_PC; dec.alusrcb = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_JAL: begin
        legal = 1'b1; imm_sel = IMM_J; is_jal = 1'b1;
        dec.aluctrl = ALU_ADD; dec.alusrca = SRCA_LINK; dec.regwrite = 1'b1;
      end
      OP_JALR: begin
        legal = (f3 == 3'b000); imm_sel = IMM_I; is_jalr = 1'b1; rs1_used = 1'b1;
        dec.aluctrl = ALU_ADD; dec.alusrca = SRCA_LINK; dec.regwrite = 1'b1;
      end
      OP_BRANCH: begin
        legal = (f3[2:1] != 2'b01); imm_sel = IMM_B; is_br = 1'b1;
        rs1_used = 1'b1; rs2_used = 1'b1;
        dec.aluctrl = ALU_SUB;
      end
      OP_LOAD: begin
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        imm_sel = IMM_I; rs1_used = 1'b1;
        dec.aluctrl = ALU_ADD; dec.alusrcb = 1'b1; dec.memread = 1'b1;
        dec.memtoreg = 1'b1; dec.regwrite = 1'b1; dec.lunsigned = f3[2];
        dec.lwhb = f3[1] ? 2'b11 : (f3[0] ? 2'b10 : 2'b01);
      end
      OP_STORE: begin
        legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
        imm_sel = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1;
        dec.aluctrl = ALU_ADD; dec.alusrcb = 1'b1; dec.memwrite = 1'b1;
        dec.swhb = f3[1] ? 2'b11 : (f3[0] ? 2'b10 : 2'b01);
      end
      OP_IMM: begin
        // only the shift-immediates constrain funct7
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
        imm_sel = IMM_I; rs1_used = 1'b1;
        dec.aluctrl = alu_of(f3, (f3 == 3'b101) && f7[5]);
        dec.alusrcb = 1'b1; dec.regwrite = 1'b1;
      end
      OP_OP: begin
        rs1_used = 1'b1; rs2_used = 1'b1; dec.regwrite = 1'b1;
        if (f7 == 7'b0000000) begin
          legal = 1'b1; dec.aluctrl = alu_of(f3, 1'b0);
        end else if (f7 == 7'b0100000) begin
          legal = (f3 == 3'b000) || (f3 == 3'b101);
          dec.aluctrl = alu_of(f3, 1'b1);
        end else if ((f7 == 7'b0000001) && (HAS_M != 0)) begin
          // M-extension: funct3 passes through as the muldiv op select
          legal = 1'b1; dec.muldiv = 1'b1; dec.aluctrl = {1'b0, f3};
          dec_isdiv = f3[2];
        end
      end
      OP_FENCE, OP_SYSTEM: begin
        // no side effects in this core: decoded as a legal nop
        legal = 1'b1;
      end
      default: ;
    endcase
    // writes to x0 are dropped at decode; non-writers carry rd=0
    if (rd_f == '0) dec.regwrite = 1'b0;
    if (!dec.regwrite) dec.rd = '0;
    else               dec.rd = rd_f;
  end

  assign immctrl    = imm_sel;
  assign bunsigned  = (opcode == OP_BRANCH) && f3[1];
  assign id_illegal = id_valid && !legal;

  // Hazard detection, stall priority and redirect selection
  always_comb begin
    id_ok     = id_valid && legal;
    busy      = (state_q == S_BUSY);
    ex_match  = (rs1_used && (rs1 == ex_q.rd)) || (rs2_used && (rs2 == ex_q.rd));
    mem_match = (rs1_used && (rs1 == mem_q.rd)) || (rs2_used && (rs2 == mem_q.rd));
    load_use  = id_ok && ex_q.memread && (ex_q.rd != '0) && ex_match;
    br_haz    = id_ok && (is_br || is_jalr) &&
                ((ex_q.regwrite && ex_match) ||
                 (mem_q.memread && mem_q.regwrite && mem_match));
    hazard    = load_use || br_haz;
    case (f3)
      3'b000:        taken = cmp_zero;
      3'b001:        taken = !cmp_zero;
      3'b100, 3'b110: taken = cmp_lt;
      default:       taken = !cmp_lt;
    endcase
    redirect  = id_ok && !busy && !hazard && (is_jal || is_jalr || (is_br && taken));
    id_stall  = busy || hazard;
    id_flush  = redirect;
    if (!redirect)    pcsrc = 2'b00;
    else if (is_jalr) pcsrc = 2'b10;
    else              pcsrc = 2'b01;
  end

  // Stage register next values: a busy divide freezes EX and bubbles MEM
  always_comb begin
    ex_d  = ex_q;
    mem_d = '0;
    if (!busy) begin
      ex_d            = (id_ok && !hazard) ? dec : '0;
      mem_d.memread   = ex_q.memread;
      mem_d.memwrite  = ex_q.memwrite;
      mem_d.lwhb      = ex_q.lwhb;
      mem_d.swhb      = ex_q.swhb;
      mem_d.lunsigned = ex_q.lunsigned;
      mem_d.regwrite  = ex_q.regwrite;
      mem_d.memtoreg  = ex_q.memtoreg;
      mem_d.rd        = ex_q.rd;
    end
    wb_d.regwrite = mem_q.regwrite;
    wb_d.memtoreg = mem_q.memtoreg;
    wb_d.rd       = mem_q.rd;
  end

  // Divide occupancy FSM: counts the extra EX cycles of a div-class op
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (id_ok && !hazard && dec_isdiv) begin
          state_d = S_BUSY;
          cnt_d   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      end
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  assign ex_busy       = busy;
  assign ex_aluctrl    = ex_q.aluctrl;
  assign ex_alusrca    = ex_q.alusrca;
  assign ex_alusrcb    = ex_q.alusrcb;
  assign ex_muldiv     = ex_q.muldiv;
  assign ex_rd         = ex_q.rd;
  assign mem_memwrite  = mem_q.memwrite;
  assign mem_lwhb      = mem_q.lwhb;
  assign mem_swhb      = mem_q.swhb;
  assign mem_lunsigned = mem_q.lunsigned;
  assign mem_rd        = mem_q.rd;
  assign wb_regwrite   = wb_q.regwrite;
  assign wb_memtoreg   = wb_q.memtoreg;
  assign wb_rd         = wb_q.rd;

endmodule
